// File: rtl/conv_pkg.sv
// Shared types and constants for the CONV layer scheduler: FSM states,
// memory-select codes and image/pool/flatten geometry.
package conv_pkg;

    localparam int IMG_W    = 64;
    localparam int POOL_W   = 32;
    localparam int L2_DEPTH = 2048;

    localparam int P_LAST = IMG_W * IMG_W - 1;
    localparam int O_LAST = POOL_W * POOL_W - 1;
    localparam int I_LAST = L2_DEPTH / 2 - 1;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CONV_REQ  = 4'd1,
        ST_CONV_WAIT = 4'd2,
        ST_CONV_W0   = 4'd3,
        ST_CONV_W1   = 4'd4,
        ST_POOL_R0   = 4'd5,
        ST_POOL_R1   = 4'd6,
        ST_POOL_R2   = 4'd7,
        ST_POOL_R3   = 4'd8,
        ST_POOL_W    = 4'd9,
        ST_FLAT_R    = 4'd10,
        ST_FLAT_W    = 4'd11
    } sched_state_e;

    // Layer-0 memory holding kernel k's results
    function automatic logic [2:0] l0_sel(input logic k);
        return k ? CSEL_L0K1 : CSEL_L0K0;
    endfunction

    // Layer-1 memory holding kernel k's pooled results
    function automatic logic [2:0] l1_sel(input logic k);
        return k ? CSEL_L1K1 : CSEL_L1K0;
    endfunction

endpackage

// File: rtl/conv_sched_addr_gen.sv
// Pixel/pool/flatten counters for the layer scheduler and the bit-concatenated
// memory addresses derived from them.
module conv_sched_addr_gen
    import conv_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_clr,
    input  logic          p_inc,
    input  logic          o_inc,
    input  logic          f_inc,
    input  logic [1:0]    pool_sub,
    output logic [AW-1:0] p_addr,
    output logic [AW-1:0] pool_rd_addr,
    output logic [AW-1:0] pool_wr_addr,
    output logic [AW-1:0] flat_rd_addr,
    output logic [AW-1:0] flat_wr_addr,
    output logic          k,
    output logic          p_last,
    output logic          pool_done,
    output logic          flat_done
);

    logic [11:0] p_q, p_d;
    logic [9:0]  o_q, o_d;
    logic [9:0]  i_q, i_d;
    logic        k_q, k_d;

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= 12'd0;
            o_q <= 10'd0;
            i_q <= 10'd0;
            k_q <= 1'b0;
        end else begin
            p_q <= p_d;
            o_q <= o_d;
            i_q <= i_d;
            k_q <= k_d;
        end
    end

    // Counter advance: pooling flips k when o wraps, flatten flips k every word
    always_comb begin
        p_d = p_q;
        o_d = o_q;
        i_d = i_q;
        k_d = k_q;
        if (cnt_clr) begin
            p_d = 12'd0;
            o_d = 10'd0;
            i_d = 10'd0;
            k_d = 1'b0;
        end else begin
            if (p_inc) begin
                p_d = p_q + 12'd1;
            end else begin
                p_d = p_q;
            end
            if (o_inc) begin
                o_d = o_q + 10'd1;
                if (o_q == 10'(O_LAST)) begin
                    k_d = ~k_q;
                end else begin
                    k_d = k_q;
                end
            end else if (f_inc) begin
                k_d = ~k_q;
                if (k_q) begin
                    i_d = i_q + 10'd1;
                end else begin
                    i_d = i_q;
                end
            end else begin
                o_d = o_q;
            end
        end
    end

    assign p_addr       = AW'(p_q);
    assign pool_rd_addr = AW'({o_q[9:5], pool_sub[1], o_q[4:0], pool_sub[0]});
    assign pool_wr_addr = AW'(o_q);
    assign flat_rd_addr = AW'(i_q);
    assign flat_wr_addr = AW'({i_q, k_q});
    assign k            = k_q;
    assign p_last       = (p_q == 12'(P_LAST));
    assign pool_done    = (o_q == 10'(O_LAST)) && k_q;
    assign flat_done    = (i_q == 10'(I_LAST)) && k_q;

endmodule

// File: rtl/conv_layer_sched.sv
// Frame scheduler for the CONV pipeline: convolution hand-off and result
// writes, 2x2 max-pool, then interleaved flatten over the shared memory port.
module conv_layer_sched
    import conv_pkg::*;
#(
    parameter int DW = 20,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          pix_valid,
    output logic [AW-1:0] pix_addr,
    input  logic          pix_ready,
    input  logic          res_valid,
    input  logic [DW-1:0] res0,
    input  logic [DW-1:0] res1,
    output logic          cwr,
    output logic          crd,
    output logic [2:0]    csel,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd
);

    sched_state_e  state_q, state_d;
    logic [DW-1:0] r0_q, r0_d;
    logic [DW-1:0] r1_q, r1_d;
    logic [DW-1:0] acc_q, acc_d;

    logic          cnt_clr_s, p_inc_s, o_inc_s, f_inc_s;
    logic [1:0]    pool_sub_s;
    logic [AW-1:0] p_addr_s, pool_rd_addr_s, pool_wr_addr_s;
    logic [AW-1:0] flat_rd_addr_s, flat_wr_addr_s;
    logic          k_s, p_last_s, pool_done_s, flat_done_s;
    logic [DW-1:0] pool_max_s;

    conv_sched_addr_gen #(.AW(AW)) u_addr_gen (
        .clk          (clk),
        .rst          (reset),
        .cnt_clr      (cnt_clr_s),
        .p_inc        (p_inc_s),
        .o_inc        (o_inc_s),
        .f_inc        (f_inc_s),
        .pool_sub     (pool_sub_s),
        .p_addr       (p_addr_s),
        .pool_rd_addr (pool_rd_addr_s),
        .pool_wr_addr (pool_wr_addr_s),
        .flat_rd_addr (flat_rd_addr_s),
        .flat_wr_addr (flat_wr_addr_s),
        .k            (k_s),
        .p_last       (p_last_s),
        .pool_done    (pool_done_s),
        .flat_done    (flat_done_s)
    );

    // Unsigned running maximum of the pooling window
    assign pool_max_s = (cdata_rd > acc_q) ? cdata_rd : acc_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r0_q    <= '0;
            r1_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            acc_q   <= acc_d;
        end
    end

    // (dy,dx) offset of the pooling window element read in this state
    always_comb begin
        case (state_q)
            ST_POOL_R1: pool_sub_s = 2'b01;
            ST_POOL_R2: pool_sub_s = 2'b10;
            ST_POOL_R3: pool_sub_s = 2'b11;
            default:    pool_sub_s = 2'b00;
        endcase
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d   = state_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        acc_d     = acc_q;
        cnt_clr_s = 1'b0;
        p_inc_s   = 1'b0;
        o_inc_s   = 1'b0;
        f_inc_s   = 1'b0;
        busy      = 1'b1;
        pix_valid = 1'b0;
        pix_addr  = '0;
        cwr       = 1'b0;
        crd       = 1'b0;
        csel      = CSEL_NONE;
        caddr_wr  = '0;
        caddr_rd  = '0;
        cdata_wr  = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (ready) begin
                    cnt_clr_s = 1'b1;
                    state_d   = ST_CONV_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV_REQ: begin
                pix_valid = 1'b1;
                pix_addr  = p_addr_s;
                if (pix_ready) begin
                    state_d = ST_CONV_WAIT;
                end else begin
                    state_d = ST_CONV_REQ;
                end
            end
            ST_CONV_WAIT: begin
                if (res_valid) begin
                    r0_d    = res0;
                    r1_d    = res1;
                    state_d = ST_CONV_W0;
                end else begin
                    state_d = ST_CONV_WAIT;
                end
            end
            ST_CONV_W0: begin
                cwr      = 1'b1;
                csel     = CSEL_L0K0;
                caddr_wr = p_addr_s;
                cdata_wr = r0_q;
                state_d  = ST_CONV_W1;
            end
            ST_CONV_W1: begin
                cwr      = 1'b1;
                csel     = CSEL_L0K1;
                caddr_wr = p_addr_s;
                cdata_wr = r1_q;
                p_inc_s  = 1'b1;
                if (p_last_s) begin
                    state_d = ST_POOL_R0;
                end else begin
                    state_d = ST_CONV_REQ;
                end
            end
            ST_POOL_R0, ST_POOL_R1, ST_POOL_R2, ST_POOL_R3: begin
                crd      = 1'b1;
                csel     = l0_sel(k_s);
                caddr_rd = pool_rd_addr_s;
                // Read data trails its strobe by one cycle, so R1 sees element 0
                if (state_q == ST_POOL_R1) begin
                    acc_d = cdata_rd;
                end else if (state_q == ST_POOL_R0) begin
                    acc_d = acc_q;
                end else begin
                    acc_d = pool_max_s;
                end
                if (state_q == ST_POOL_R0) begin
                    state_d = ST_POOL_R1;
                end else if (state_q == ST_POOL_R1) begin
                    state_d = ST_POOL_R2;
                end else if (state_q == ST_POOL_R2) begin
                    state_d = ST_POOL_R3;
                end else begin
                    state_d = ST_POOL_W;
                end
            end
            ST_POOL_W: begin
                cwr      = 1'b1;
                csel     = l1_sel(k_s);
                caddr_wr = pool_wr_addr_s;
                cdata_wr = pool_max_s;
                o_inc_s  = 1'b1;
                if (pool_done_s) begin
                    state_d = ST_FLAT_R;
                end else begin
                    state_d = ST_POOL_R0;
                end
            end
            ST_FLAT_R: begin
                crd      = 1'b1;
                csel     = l1_sel(k_s);
                caddr_rd = flat_rd_addr_s;
                state_d  = ST_FLAT_W;
            end
            ST_FLAT_W: begin
                cwr      = 1'b1;
                csel     = CSEL_L2;
                caddr_wr = flat_wr_addr_s;
                cdata_wr = cdata_rd;
                f_inc_s  = 1'b1;
                if (flat_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLAT_R;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: engine model (L=3), memory model with
// preload pokes between layers, on-the-fly write checking and protocol monitor.
module tb_conv_layer_sched;
    import conv_pkg::*;

    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          busy;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic          pix_ready;
    logic          res_valid;
    logic [DW-1:0] res0;
    logic [DW-1:0] res1;
    logic          cwr;
    logic          crd;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd = '0;

    always #5 clk = ~clk;

    conv_layer_sched #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_addr  (pix_addr),
        .pix_ready (pix_ready),
        .res_valid (res_valid),
        .res0      (res0),
        .res1      (res1),
        .cwr       (cwr),
        .crd       (crd),
        .csel      (csel),
        .caddr_wr  (caddr_wr),
        .caddr_rd  (caddr_rd),
        .cdata_wr  (cdata_wr),
        .cdata_rd  (cdata_rd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected pooled value; L0K0 window at o=0 and address 4095 are poked
    function automatic logic [19:0] pool_exp(input logic kk, input logic [9:0] o);
        logic [11:0] base;
        base = {o[9:5], 1'b0, o[4:0], 1'b0};
        if (kk)                 return ~{8'h00, base};
        else if (o == 10'd0)    return 20'd9;
        else if (o == 10'd1023) return 20'hFFFFF;
        else                    return {8'h00, base + 12'd65};
    endfunction

    function automatic logic [19:0] flat_exp(input logic [10:0] a);
        return (a[0] ? 20'h80000 : 20'h00000) | {10'd0, a[10:1]};
    endfunction

    // Conv engine: fixed latency 3, res0=p, res1=~p
    logic [1:0]    lat_cnt = 2'd0;
    logic [AW-1:0] lat_p = '0;
    logic          spur;
    always @(posedge clk) begin
        if (reset) lat_cnt <= 2'd0;
        else if (pix_valid && pix_ready) begin
            lat_cnt <= 2'd3;
            lat_p   <= pix_addr;
        end else if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
    end
    assign res_valid = (lat_cnt == 2'd1) | spur;
    assign res0      = {8'h00, lat_p};
    assign res1      = ~{8'h00, lat_p};

    logic [19:0] l0k0 [0:4095];
    logic [19:0] l0k1 [0:4095];
    logic [19:0] l1k0 [0:1023];
    logic [19:0] l1k1 [0:1023];
    logic [19:0] l2   [0:2047];

    logic stats_clr;
    int   n_l0, n_l1, n_l2, l0_err, l1_err, l2_err, crd_in_l0, proto_err;
    logic l0_done;
    logic [19:0] cap0, cap1023;

    // Memory model plus per-write scoreboard
    always @(posedge clk) begin
        if (crd) begin
            case (csel)
                CSEL_L0K0: cdata_rd <= l0k0[caddr_rd];
                CSEL_L0K1: cdata_rd <= l0k1[caddr_rd];
                CSEL_L1K0: cdata_rd <= l1k0[caddr_rd[9:0]];
                CSEL_L1K1: cdata_rd <= l1k1[caddr_rd[9:0]];
                default:   cdata_rd <= 20'hDEAD0;
            endcase
        end
        if (cwr) begin
            case (csel)
                CSEL_L0K0: l0k0[caddr_wr] <= cdata_wr;
                CSEL_L0K1: l0k1[caddr_wr] <= cdata_wr;
                CSEL_L1K0: l1k0[caddr_wr[9:0]] <= cdata_wr;
                CSEL_L1K1: l1k1[caddr_wr[9:0]] <= cdata_wr;
                CSEL_L2:   l2[caddr_wr[10:0]] <= cdata_wr;
                default: ;
            endcase
            if (csel == CSEL_L0K1 && caddr_wr == 12'd4095) begin
                l0k0[0] <= 20'd5;  l0k0[1]  <= 20'd9;
                l0k0[64] <= 20'd2; l0k0[65] <= 20'd7;
                l0k0[4095] <= 20'hFFFFF;
            end
            if (csel == CSEL_L1K1 && caddr_wr == 12'd1023) begin
                for (int j = 0; j < 1024; j++) begin
                    l1k0[j] <= 20'(j);
                    l1k1[j] <= 20'h80000 | 20'(j);
                end
            end
        end
        if (stats_clr) begin
            n_l0 <= 0; n_l1 <= 0; n_l2 <= 0;
            l0_err <= 0; l1_err <= 0; l2_err <= 0;
            crd_in_l0 <= 0; proto_err <= 0; l0_done <= 1'b0;
            cap0 <= '0; cap1023 <= '0;
        end else begin
            if (crd && !l0_done) crd_in_l0 <= crd_in_l0 + 1;
            if ((cwr && crd) || ((cwr || crd) && csel == CSEL_NONE)) proto_err <= proto_err + 1;
            if (cwr && (csel == CSEL_L0K0 || csel == CSEL_L0K1)) begin
                n_l0 <= n_l0 + 1;
                if (cdata_wr != ((csel == CSEL_L0K0) ? {8'h00, caddr_wr} : ~{8'h00, caddr_wr}))
                    l0_err <= l0_err + 1;
                if (csel == CSEL_L0K1 && caddr_wr == 12'd4095) l0_done <= 1'b1;
            end
            if (cwr && (csel == CSEL_L1K0 || csel == CSEL_L1K1)) begin
                n_l1 <= n_l1 + 1;
                if (cdata_wr != pool_exp(csel == CSEL_L1K1, caddr_wr[9:0])) l1_err <= l1_err + 1;
                if (csel == CSEL_L1K0 && caddr_wr == 12'd0)    cap0 <= cdata_wr;
                if (csel == CSEL_L1K0 && caddr_wr == 12'd1023) cap1023 <= cdata_wr;
            end
            if (cwr && csel == CSEL_L2) begin
                n_l2 <= n_l2 + 1;
                if (cdata_wr != flat_exp(caddr_wr[10:0])) l2_err <= l2_err + 1;
            end
        end
    end

    task automatic wait_write(input logic [2:0] sel, input logic [AW-1:0] addr,
                              input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (cwr && csel == sel && caddr_wr == addr) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int   hold_bad;
        int   n_l1_snap;
        logic reached;
        reset = 1'b1; ready = 1'b0; pix_ready = 1'b1; spur = 1'b0; stats_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({busy, pix_valid, cwr, crd, csel}), 32'd0);
        check("rst_addr", 32'({pix_addr, caddr_wr, caddr_rd}), 32'd0);
        check("rst_wdata", 32'(cdata_wr), 32'd0);
        reset = 1'b0;
        stats_clr = 1'b0;

        // Frame 1: aborted by reset in the middle of Layer 1
        @(negedge clk);
        check("idle_no_ready", 32'(busy), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("busy_rise", 32'(busy), 32'd1);
        ready = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 30000 && !reached; c++) begin
            @(negedge clk);
            if (n_l1 >= 100) reached = 1'b1;
        end
        check("reach_l1", 32'(reached), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_ctrl", 32'({busy, pix_valid, cwr, crd, csel}), 32'd0);
        check("midrst_addr", 32'({caddr_wr, caddr_rd}), 32'd0);
        n_l1_snap = n_l1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_wr", 32'(n_l1), 32'(n_l1_snap));
        reset = 1'b0;
        stats_clr = 1'b1;

        // Frame 2: full run with stall and spurious result strobe
        @(negedge clk);
        stats_clr = 1'b0;
        check("busy_after_rst", 32'(busy), 32'd1);
        ready = 1'b0;
        wait_write(CSEL_L0K1, 12'd99, "wait_p99", 2000);
        pix_ready = 1'b0;
        hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || pix_addr !== 12'd100) hold_bad++;
        end
        check("stall_hold", 32'(hold_bad), 32'd0);
        pix_ready = 1'b1;
        wait_write(CSEL_L0K1, 12'd101, "wait_p101", 200);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        wait_write(CSEL_L2, 12'd2047, "wait_l2_last", 45000);
        check("busy_last_wr", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        check("idle_stays", 32'(busy), 32'd0);

        check("l0_writes", 32'(n_l0), 32'd8192);
        check("l0_data_err", 32'(l0_err), 32'd0);
        check("l0_no_crd", 32'(crd_in_l0), 32'd0);
        check("l1_writes", 32'(n_l1), 32'd2048);
        check("l1_data_err", 32'(l1_err), 32'd0);
        check("l1k0_0", 32'(cap0), 32'd9);
        check("l1k0_1023", 32'(cap1023), 32'hFFFFF);
        check("l2_writes", 32'(n_l2), 32'd2048);
        check("l2_data_err", 32'(l2_err), 32'd0);
        check("l2_0", 32'(l2[0]), 32'd0);
        check("l2_1", 32'(l2[1]), 32'h80000);
        check("l2_2046", 32'(l2[2046]), 32'd1023);
        check("l2_2047", 32'(l2[2047]), 32'h803FF);
        check("protocol", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
